// File: rtl/aes_iterative_decryptor.sv
// aes_iterative_decryptor: AES inverse cipher, one round per clock.
// Optional round-key capture register: define AES_DEC_KEY_LATCH_EN.
module aes_inv_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);
  function automatic logic [7:0] gmul(
    input logic [7:0] x,
    input logic [7:0] z
  );
    logic [7:0] p;
    logic [7:0] t;
    p = '0;
    t = x;
    for (int i = 0; i < 8; i++) begin
      if (z[i]) p = p ^ t;
      t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // x^254 is the field inverse, with 0 mapping to 0
  function automatic logic [7:0] ginv(input logic [7:0] x);
    logic [7:0] p;
    logic [7:0] r;
    p = x;
    r = 8'h01;
    for (int i = 1; i < 8; i++) begin
      p = gmul(p, p);
      r = gmul(r, p);
    end
    return r;
  endfunction

  logic [7:0] u;

  // inverse affine transform, then field inverse
  assign u = {a[6:0], a[7]} ^ {a[4:0], a[7:5]}
           ^ {a[1:0], a[7:2]} ^ 8'h05;
  assign y = ginv(u);
endmodule

module aes_iterative_decryptor #(
  parameter int nk = 8,
  parameter int nb = 4,
  parameter int nr = 14
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [32*nb-1:0]          in_cipher,
  input  logic [32*nb*(nr+1)-1:0]   w,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [32*nb-1:0]          out_msg
);
  localparam int bw = 32*nb;
  localparam int kw_w = bw*(nr+1);

  if (!(nb == 4 && ((nk == 4 && nr == 10) ||
        (nk == 6 && nr == 12) ||
        (nk == 8 && nr == 14)))) begin : g_bad
    $error("aes_iterative_decryptor: bad nk/nb/nr");
  end

  typedef enum logic [1:0] {IDLE, ROUND, DONE} fsm_t;

  fsm_t            cs;
  fsm_t            ns;
  logic [bw-1:0]   st;
  logic [3:0]      rnd;
  logic            acc;
  logic [kw_w-1:0] kw;
  logic [bw-1:0]   rk_arr [nr+1];
  logic [bw-1:0]   sb;
  logic [bw-1:0]   sr;
  logic [bw-1:0]   ark;

  function automatic logic [7:0] gmul(
    input logic [7:0] x,
    input logic [7:0] z
  );
    logic [7:0] p;
    logic [7:0] t;
    p = '0;
    t = x;
    for (int i = 0; i < 8; i++) begin
      if (z[i]) p = p ^ t;
      t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [127:0] inv_mix(
    input logic [127:0] s
  );
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[32*c+24 +: 8];
      a1 = s[32*c+16 +: 8];
      a2 = s[32*c+8 +: 8];
      a3 = s[32*c +: 8];
      o[32*c+24 +: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b)
                      ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
      o[32*c+16 +: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e)
                      ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
      o[32*c+8 +: 8]  = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09)
                      ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
      o[32*c +: 8]    = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d)
                      ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
    end
    return o;
  endfunction

`ifdef AES_DEC_KEY_LATCH_EN
  logic [kw_w-1:0] kreg;

  // snapshot the schedule so the caller may change w after accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) kreg <= '0;
    else if (acc) kreg <= w;
  end

  assign kw = kreg;
`else
  assign kw = w;
`endif

  for (genvar i = 0; i <= nr; i++) begin : g_rk
    assign rk_arr[i] = kw[bw*i +: bw];
  end

  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      aes_inv_sbox u_sb (
        .a (st[32*c+24-8*r +: 8]),
        .y (sb[32*c+24-8*r +: 8])
      );
      assign sr[32*c+24-8*r +: 8] =
        sb[32*((c+4-r)%4)+24-8*r +: 8];
    end
  end

  assign ark = sr ^ rk_arr[rnd];
  assign out_msg = st;

  // control state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cs <= IDLE;
    else cs <= ns;
  end

  // next state and handshake outputs
  always_comb begin
    ns = cs;
    in_ready = 1'b0;
    out_valid = 1'b0;
    unique case (cs)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) ns = ROUND;
      end
      ROUND: begin
        if (rnd == 4'd0) ns = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        in_ready = out_ready;
        if (out_ready) ns = in_valid ? ROUND : IDLE;
      end
      default: ns = IDLE;
    endcase
    acc = in_ready & in_valid;
  end

  // block state and round counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st <= '0;
      rnd <= '0;
    end else if (acc) begin
      st <= in_cipher ^ rk_arr[nr];
      rnd <= 4'(nr - 1);
    end else if (cs == ROUND) begin
      if (rnd != 4'd0) begin
        st <= inv_mix(ark);
        rnd <= rnd - 4'd1;
      end else begin
        st <= ark;
      end
    end
  end
endmodule

// File: tb/tb_aes_iterative_decryptor.sv
// tb_aes_iterative_decryptor: scoreboard bench, forward-cipher model.
// Key-capture case runs only with AES_DEC_KEY_LATCH_EN defined.
module tb_aes_iterative_decryptor;
  localparam int NR = 14;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           in_valid, in_ready;
  logic           out_valid, out_ready;
  logic [127:0]   in_cipher, out_msg;
  logic [1919:0]  w;
  logic           in_valid_b, in_ready_b;
  logic           out_valid_b, out_ready_b;
  logic [127:0]   in_cipher_b, out_msg_b;
  logic [1407:0]  w_b;

  aes_iterative_decryptor #(.nk(8), .nb(4), .nr(14)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_cipher(in_cipher), .w(w),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_msg(out_msg)
  );

  aes_iterative_decryptor #(.nk(4), .nb(4), .nr(10)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid_b), .in_ready(in_ready_b),
    .in_cipher(in_cipher_b), .w(w_b),
    .out_valid(out_valid_b), .out_ready(out_ready_b),
    .out_msg(out_msg_b)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int done_acc = 0;
  logic [127:0] exp_q [$];
  int acc_q [$];
  int xfer_q [$];
  logic [7:0] sbox_t [256];
  bit seen = 0;
  logic [127:0] held;

  task automatic chk(input string nm,
                     input logic [127:0] act,
                     input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic bad(input string nm);
    vectors++;
    miscompares++;
    $display("FAIL %s: event missing or unexpected", nm);
  endtask

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] a,
                                    input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] t;
    p = '0;
    t = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ t;
      t = xt(t);
    end
    return p;
  endfunction

  function automatic logic [7:0] rl(input logic [7:0] v,
                                    input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  // forward S-box: brute-force inverse, then affine map
  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox_t[x] = inv ^ rl(inv, 1) ^ rl(inv, 2)
                ^ rl(inv, 3) ^ rl(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic int bl(input int r, input int c);
    return 32*c + 24 - 8*r;
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] x);
    return {sbox_t[x[31:24]], sbox_t[x[23:16]],
            sbox_t[x[15:8]], sbox_t[x[7:0]]};
  endfunction

  function automatic logic [1919:0] expand(
    input logic [255:0] key, input int nk, input int nr
  );
    logic [31:0]   ws [60];
    logic [31:0]   t;
    logic [7:0]    rc;
    logic [1919:0] f;
    rc = 8'h01;
    f = '0;
    for (int i = 0; i < nk; i++) ws[i] = key[32*i +: 32];
    for (int i = nk; i < 4*(nr+1); i++) begin
      t = ws[i-1];
      if (i % nk == 0) begin
        t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = xt(rc);
      end else if (nk > 6 && i % nk == 4) begin
        t = subw(t);
      end
      ws[i] = ws[i-nk] ^ t;
    end
    for (int i = 0; i < 4*(nr+1); i++) f[32*i +: 32] = ws[i];
    return f;
  endfunction

  function automatic logic [127:0] encrypt(
    input logic [127:0] pt, input logic [1919:0] ks,
    input int nr
  );
    logic [127:0] s, o;
    logic [7:0]   a0, a1, a2, a3;
    s = pt ^ ks[127:0];
    for (int rd = 1; rd <= nr; rd++) begin
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          o[bl(r, c) +: 8] = sbox_t[s[bl(r, (c+r)%4) +: 8]];
      s = o;
      if (rd != nr) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[bl(0, c) +: 8];
          a1 = s[bl(1, c) +: 8];
          a2 = s[bl(2, c) +: 8];
          a3 = s[bl(3, c) +: 8];
          o[bl(0, c) +: 8] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
          o[bl(1, c) +: 8] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
          o[bl(2, c) +: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
          o[bl(3, c) +: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end
        s = o;
      end
      s = s ^ ks[128*rd +: 128];
    end
    return s;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  function automatic logic [255:0] rnd256();
    return {rnd128(), rnd128()};
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // output monitor: latency, stability while stalled, data
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      seen = 0;
    end else if (out_valid) begin
      if (!seen) begin
        seen = 1;
        held = out_msg;
        if (acc_q.size() == 0) bad("latency_no_accept");
        else chk("latency", cyc - acc_q[0], NR);
      end else begin
        chk("stall_stable", out_msg, held);
      end
      if (out_ready) begin
        if (exp_q.size() == 0) begin
          bad("unexpected_output");
        end else begin
          chk("plaintext", out_msg, exp_q.pop_front());
          void'(acc_q.pop_front());
        end
        xfer_q.push_back(cyc);
        seen = 0;
      end
    end
  end

  task automatic send(input logic [127:0] pt,
                      input logic [127:0] ct);
    bit ok;
    ok = 0;
    in_valid = 1'b1;
    in_cipher = ct;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      bad("accept_timeout");
    end else begin
      exp_q.push_back(pt);
      acc_q.push_back(cyc + 1);
      if (out_valid) done_acc++;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && exp_q.size() != 0; i++)
      @(negedge clk);
    if (exp_q.size() != 0) begin
      bad("drain_timeout");
      exp_q.delete();
      acc_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run128(input logic [127:0] pt,
                        input logic [127:0] ct);
    int lat;
    bit got;
    in_valid_b = 1'b1;
    in_cipher_b = ct;
    @(negedge clk);
    chk("b_in_ready", in_ready_b, 1'b1);
    @(posedge clk);
    #1;
    in_valid_b = 1'b0;
    lat = 0;
    got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (out_valid_b) got = 1;
      else lat++;
    end
    if (!got) begin
      bad("b_out_timeout");
    end else begin
      chk("b_latency", lat, 10);
      chk("b_plaintext", out_msg_b, pt);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1919:0] ks;
    logic [127:0]  pt;
    bit            got;
    build_sbox();
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_cipher = '0;
    out_ready = 1'b1;
    w = '0;
    in_valid_b = 1'b0;
    in_cipher_b = '0;
    out_ready_b = 1'b1;
    w_b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_msg", out_msg, '0);
    rst_n = 1'b1;

    w = expand({128'h1c1d1e1f18191a1b1415161710111213,
                128'h0c0d0e0f08090a0b0405060700010203},
               8, 14);
    @(posedge clk);
    #1;
    send(128'hccddeeff8899aabb4455667700112233,
         128'h4b496089eafc4990516745bf8ea2b7ca);
    drain();

    ks = expand({128'h0,
                 128'h0c0d0e0f08090a0b0405060700010203},
                4, 10);
    w_b = ks[1407:0];
    run128(128'hccddeeff8899aabb4455667700112233,
           128'h70b4c55ad8cdb7806a7b043069c4e0d8);
    for (int i = 0; i < 2; i++) begin
      ks = expand({128'h0, rnd128()}, 4, 10);
      w_b = ks[1407:0];
      pt = rnd128();
      run128(pt, encrypt(pt, ks, 10));
    end

    for (int i = 0; i < 3; i++) begin
      w = expand(rnd256(), 8, 14);
      pt = rnd128();
      send(pt, encrypt(pt, w, 14));
      drain();
    end

    xfer_q.delete();
    out_ready = 1'b0;
    pt = rnd128();
    send(pt, encrypt(pt, w, 14));
    got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (out_valid) got = 1;
    end
    if (!got) bad("bp_out_timeout");
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      in_valid = (i % 3 == 0);
      in_cipher = rnd128();
      @(negedge clk);
      chk("bp_in_ready", in_ready, 1'b0);
      chk("bp_out_valid", out_valid, 1'b1);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_in_ready_after", in_ready, 1'b1);
    chk("bp_out_valid_after", out_valid, 1'b0);
    chk("bp_xfers", xfer_q.size(), 1);
    drain();

    xfer_q.delete();
    done_acc = 0;
    w = expand(rnd256(), 8, 14);
    for (int i = 0; i < 4; i++) begin
      pt = rnd128() ^ 128'(i);
      send(pt, encrypt(pt, w, 14));
    end
    drain();
    chk("b2b_count", xfer_q.size(), 4);
    for (int i = 1; i < xfer_q.size(); i++)
      chk("b2b_spacing", xfer_q[i] - xfer_q[i-1], 15);
    chk("b2b_done_accepts", done_acc, 3);

    pt = rnd128();
    send(pt, encrypt(pt, w, 14));
    repeat (7) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", out_valid, 1'b0);
    chk("mid_rst_out_msg", out_msg, '0);
    chk("mid_rst_in_ready", in_ready, 1'b1);
    exp_q.delete();
    acc_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    pt = rnd128();
    send(pt, encrypt(pt, w, 14));
    drain();

`ifdef AES_DEC_KEY_LATCH_EN
    ks = expand(rnd256(), 8, 14);
    w = ks;
    pt = rnd128();
    send(pt, encrypt(pt, ks, 14));
    w = '1;
    drain();
    w = ks;
`endif

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end
endmodule
